// File: rtl/stu_pe_upstream_arbiter_if.sv
// Upstream stack-bus channel bundles: per-PE side (PE array -> arbiter) and the merged link.
// Pure wiring. No latency.
// Backpressure is carried by stu__pe__ready and sys__stu__ready.
interface stu_pe_up_if #(
    parameter int NUM_PE = 64,
    parameter int DATA_W = 64,
    parameter int OOB_W  = 32,
    parameter int TYPE_W = 2,
    parameter int CNTL_W = 2
);
    logic [NUM_PE-1:0]        pe__stu__valid;
    logic [NUM_PE*CNTL_W-1:0] pe__stu__cntl;
    logic [NUM_PE*TYPE_W-1:0] pe__stu__type;
    logic [NUM_PE*DATA_W-1:0] pe__stu__data;
    logic [NUM_PE*OOB_W-1:0]  pe__stu__oob_data;
    logic [NUM_PE-1:0]        stu__pe__ready;

    modport master (
        output pe__stu__valid, pe__stu__cntl, pe__stu__type, pe__stu__data, pe__stu__oob_data,
        input  stu__pe__ready
    );
    modport slave (
        input  pe__stu__valid, pe__stu__cntl, pe__stu__type, pe__stu__data, pe__stu__oob_data,
        output stu__pe__ready
    );
endinterface

interface stu_sys_up_if #(
    parameter int DATA_W  = 64,
    parameter int OOB_W   = 32,
    parameter int TYPE_W  = 2,
    parameter int CNTL_W  = 2,
    parameter int PE_ID_W = 6,
    parameter int CNT_W   = 16
);
    logic               stu__sys__valid;
    logic [CNTL_W-1:0]  stu__sys__cntl;
    logic [TYPE_W-1:0]  stu__sys__type;
    logic [DATA_W-1:0]  stu__sys__data;
    logic [OOB_W-1:0]   stu__sys__oob_data;
    logic [PE_ID_W-1:0] stu__sys__pe_id;
    logic               sys__stu__ready;
    logic [CNT_W-1:0]   stu__sys__msg_count;
    logic               stu__sys__proto_err;

    modport master (
        output stu__sys__valid, stu__sys__cntl, stu__sys__type, stu__sys__data,
               stu__sys__oob_data, stu__sys__pe_id, stu__sys__msg_count, stu__sys__proto_err,
        input  sys__stu__ready
    );
    modport slave (
        input  stu__sys__valid, stu__sys__cntl, stu__sys__type, stu__sys__data,
               stu__sys__oob_data, stu__sys__pe_id, stu__sys__msg_count, stu__sys__proto_err,
        output sys__stu__ready
    );
endinterface

// File: rtl/stu_pe_upstream_arbiter.sv
// Round-robin merge of per-PE upstream channels onto one link, locked per message.
// Latency: accepted beat is visible on stu__sys__* one cycle later (2-entry registered FIFO).
// Backpressure: PE ready is combinational from valid and drops to 0 whenever the FIFO holds 2 beats.
module stu_pe_upstream_arbiter #(
    parameter int NUM_PE = 64,
    parameter int DATA_W = 64,
    parameter int OOB_W  = 32,
    parameter int TYPE_W = 2,
    parameter int CNTL_W = 2,
    parameter int CNT_W  = 16
) (
    input  logic       clk,
    input  logic       reset_poweron,
    stu_pe_up_if.slave pe,
    stu_sys_up_if.master sys
);
    localparam int PID_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    localparam logic [CNTL_W-1:0] C_SOM_EOM = CNTL_W'(0);
    localparam logic [CNTL_W-1:0] C_SOM     = CNTL_W'(1);
    localparam logic [CNTL_W-1:0] C_MOM     = CNTL_W'(2);
    localparam logic [CNTL_W-1:0] C_EOM     = CNTL_W'(3);

    typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_e;

    typedef struct packed {
        logic [CNTL_W-1:0] cntl;
        logic [TYPE_W-1:0] typ;
        logic [DATA_W-1:0] data;
        logic [OOB_W-1:0]  oob;
        logic [PID_W-1:0]  pe_id;
    } beat_t;

    state_e           state_q, state_d;
    logic [PID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [PID_W-1:0] lock_id_q, lock_id_d;
    beat_t            ent0_q, ent0_d, ent1_q, ent1_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] msg_q, msg_d;
    logic             err_q, err_d;

    logic             grant_vld;
    logic [PID_W-1:0] grant_id;
    logic [PID_W-1:0] sel_id, next_id;
    logic             sel_en, fifo_ok, accept, pop;
    logic [1:0]       cnt_pop;
    logic [NUM_PE-1:0] ready;
    beat_t            in_beat;

    // First valid PE at or after rr_ptr, wrapping modulo NUM_PE.
    always_comb begin
        int idx;
        grant_vld = 1'b0;
        grant_id  = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_PE) idx = idx - NUM_PE;
            if (!grant_vld && pe.pe__stu__valid[idx]) begin
                grant_vld = 1'b1;
                grant_id  = PID_W'(idx);
            end
        end
    end

    always_comb begin
        fifo_ok = (cnt_q != 2'd2);
        sel_id  = (state_q == ST_LOCKED) ? lock_id_q : grant_id;
        sel_en  = (state_q == ST_LOCKED) || grant_vld;
        ready   = '0;
        if (sel_en && fifo_ok && !reset_poweron) ready[sel_id] = 1'b1;
        accept  = sel_en && fifo_ok && !reset_poweron && pe.pe__stu__valid[sel_id];
        next_id = (sel_id == PID_W'(NUM_PE - 1)) ? '0 : sel_id + PID_W'(1);
        pop     = (cnt_q != 2'd0) && sys.sys__stu__ready;

        in_beat = '{cntl:  pe.pe__stu__cntl[sel_id*CNTL_W +: CNTL_W],
                    typ:   pe.pe__stu__type[sel_id*TYPE_W +: TYPE_W],
                    data:  pe.pe__stu__data[sel_id*DATA_W +: DATA_W],
                    oob:   pe.pe__stu__oob_data[sel_id*OOB_W +: OOB_W],
                    pe_id: sel_id};

        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        lock_id_d = lock_id_q;
        err_d     = err_q;
        if (accept) begin
            if (state_q == ST_IDLE) begin
                if (in_beat.cntl == C_SOM || in_beat.cntl == C_MOM) begin
                    lock_id_d = sel_id;
                    state_d   = ST_LOCKED;
                end else begin
                    rr_ptr_d = next_id;
                end
            end else begin
                // A new start while locked is flagged but still forwarded.
                if (in_beat.cntl == C_SOM || in_beat.cntl == C_SOM_EOM) err_d = 1'b1;
                if (in_beat.cntl == C_EOM || in_beat.cntl == C_SOM_EOM) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = next_id;
                end
            end
        end

        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        cnt_pop = cnt_q - {1'b0, pop};
        if (pop) ent0_d = ent1_q;
        if (accept) begin
            if (cnt_pop == 2'd0) ent0_d = in_beat;
            else                 ent1_d = in_beat;
        end
        cnt_d = cnt_pop + {1'b0, accept};

        msg_d = msg_q;
        if (pop && (ent0_q.cntl == C_EOM || ent0_q.cntl == C_SOM_EOM)) msg_d = msg_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            lock_id_q <= '0;
            ent0_q    <= '0;
            ent1_q    <= '0;
            cnt_q     <= 2'd0;
            msg_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            lock_id_q <= lock_id_d;
            ent0_q    <= ent0_d;
            ent1_q    <= ent1_d;
            cnt_q     <= cnt_d;
            msg_q     <= msg_d;
            err_q     <= err_d;
        end
    end

    assign pe.stu__pe__ready       = ready;
    assign sys.stu__sys__valid     = (cnt_q != 2'd0);
    assign sys.stu__sys__cntl      = ent0_q.cntl;
    assign sys.stu__sys__type      = ent0_q.typ;
    assign sys.stu__sys__data      = ent0_q.data;
    assign sys.stu__sys__oob_data  = ent0_q.oob;
    assign sys.stu__sys__pe_id     = ent0_q.pe_id;
    assign sys.stu__sys__msg_count = msg_q;
    assign sys.stu__sys__proto_err = err_q;
endmodule

// File: tb/tb_stu_pe_upstream_arbiter.sv
// Bench for stu_pe_upstream_arbiter: directed scenarios plus a randomized run against a queue-based model.
module tb_stu_pe_upstream_arbiter;
    localparam int NP = 8, DW = 16, OW = 8, TW = 2, CW = 2, CNTW = 8, PIDW = 3;
    localparam logic [1:0] SOM_EOM = 2'd0, SOM = 2'd1, MOM = 2'd2, EOM = 2'd3;

    typedef struct packed {
        logic [1:0]      cntl;
        logic [1:0]      typ;
        logic [DW-1:0]   data;
        logic [OW-1:0]   oob;
        logic [PIDW-1:0] pe;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stu_pe_up_if #(.NUM_PE(NP), .DATA_W(DW), .OOB_W(OW), .TYPE_W(TW), .CNTL_W(CW)) pe_if ();
    stu_sys_up_if #(.DATA_W(DW), .OOB_W(OW), .TYPE_W(TW), .CNTL_W(CW), .PE_ID_W(PIDW), .CNT_W(CNTW)) sys_if ();

    stu_pe_upstream_arbiter #(.NUM_PE(NP), .DATA_W(DW), .OOB_W(OW), .TYPE_W(TW), .CNTL_W(CW), .CNT_W(CNTW)) dut (
        .clk(clk), .reset_poweron(rst), .pe(pe_if), .sys(sys_if)
    );

    beat_t src_q[NP][$];
    beat_t mq[$];
    beat_t obs_log[$];
    beat_t exp_log[$];
    int    obs_cyc[$];
    int    m_lock = -1, m_rr = 0;
    logic [CNTW-1:0] m_msg = '0;
    logic  m_err = 1'b0;

    int errors = 0, checks = 0, cyc = 0;
    int ready_mm = 0, valid_mm = 0, cnt_mm = 0, stall_mm = 0, dut_acc = 0;
    int rdy_mode = 1, bubble_pct = 0;
    logic [NP-1:0]   s_ready;
    logic            s_valid, s_err, prev_stall = 1'b0;
    logic [CNTW-1:0] s_cnt;
    beat_t           s_out, prev_out;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic enq(input int p, input logic [1:0] c, input logic [DW-1:0] d);
        beat_t b;
        b.cntl = c;
        b.typ  = TW'($urandom_range(3));
        b.data = d;
        b.oob  = OW'($urandom);
        b.pe   = PIDW'(p);
        src_q[p].push_back(b);
    endtask

    task automatic drive_inputs();
        beat_t b;
        for (int i = 0; i < NP; i++) begin
            b = '0;
            if (src_q[i].size() != 0) b = src_q[i][0];
            pe_if.pe__stu__valid[i] = (src_q[i].size() != 0) && ($urandom_range(99) >= bubble_pct);
            pe_if.pe__stu__cntl[i*CW +: CW]     = b.cntl;
            pe_if.pe__stu__type[i*TW +: TW]     = b.typ;
            pe_if.pe__stu__data[i*DW +: DW]     = b.data;
            pe_if.pe__stu__oob_data[i*OW +: OW] = b.oob;
        end
        case (rdy_mode)
            0:       sys_if.sys__stu__ready = 1'b0;
            1:       sys_if.sys__stu__ready = 1'b1;
            default: sys_if.sys__stu__ready = 1'($urandom_range(1));
        endcase
    endtask

    // One clock: drive, sample at negedge, advance the message-level model.
    task automatic step();
        logic [NP-1:0] exp_ready;
        int sel;
        logic fifo_ok, acc, pop;
        beat_t nb;
        drive_inputs();
        @(negedge clk);
        cyc++;
        s_ready = pe_if.stu__pe__ready;
        s_valid = sys_if.stu__sys__valid;
        s_out   = {sys_if.stu__sys__cntl, sys_if.stu__sys__type, sys_if.stu__sys__data,
                   sys_if.stu__sys__oob_data, sys_if.stu__sys__pe_id};
        s_cnt   = sys_if.stu__sys__msg_count;
        s_err   = sys_if.stu__sys__proto_err;
        if (|(s_ready & pe_if.pe__stu__valid)) dut_acc++;
        if (prev_stall && (!s_valid || s_out !== prev_out)) stall_mm++;
        prev_stall = !rst && s_valid && !sys_if.sys__stu__ready;
        prev_out   = s_out;

        fifo_ok   = mq.size() < 2;
        sel       = -1;
        exp_ready = '0;
        if (!rst) begin
            if (m_lock >= 0) sel = m_lock;
            else for (int k = 0; k < NP; k++)
                if (sel < 0 && pe_if.pe__stu__valid[(m_rr + k) % NP]) sel = (m_rr + k) % NP;
            if (sel >= 0 && fifo_ok) exp_ready[sel] = 1'b1;
        end
        if (s_ready !== exp_ready) ready_mm++;
        if (s_valid !== (mq.size() != 0)) valid_mm++;
        if (s_cnt !== m_msg || s_err !== m_err) cnt_mm++;

        if (rst) begin
            mq.delete();
            m_lock = -1; m_rr = 0; m_msg = '0; m_err = 1'b0;
            prev_stall = 1'b0;
        end else begin
            pop = (mq.size() != 0) && sys_if.sys__stu__ready;
            acc = (sel >= 0) && fifo_ok && pe_if.pe__stu__valid[sel];
            if (s_valid && sys_if.sys__stu__ready) begin
                obs_log.push_back(s_out);
                obs_cyc.push_back(cyc);
            end
            if (pop) begin
                exp_log.push_back(mq[0]);
                if (mq[0].cntl == EOM || mq[0].cntl == SOM_EOM) m_msg++;
                void'(mq.pop_front());
            end
            if (acc) begin
                nb = src_q[sel].pop_front();
                mq.push_back(nb);
                if (m_lock < 0) begin
                    if (nb.cntl == SOM || nb.cntl == MOM) m_lock = sel;
                    else m_rr = (sel + 1) % NP;
                end else begin
                    if (nb.cntl == SOM || nb.cntl == SOM_EOM) m_err = 1'b1;
                    if (nb.cntl == EOM || nb.cntl == SOM_EOM) begin
                        m_lock = -1;
                        m_rr = (sel + 1) % NP;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_until(input int n, input int budget, output bit ok);
        int k = 0;
        while (obs_log.size() < n && k < budget) begin
            step();
            k++;
        end
        ok = (obs_log.size() >= n);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int p = 0; p < NP; p++) src_q[p].delete();
        step();
        step();
        rst = 1'b0;
        obs_log.delete(); exp_log.delete(); obs_cyc.delete();
        ready_mm = 0; valid_mm = 0; cnt_mm = 0; stall_mm = 0; dut_acc = 0;
        bubble_pct = 0; rdy_mode = 1;
    endtask

    task automatic test_reset();
        do_reset();
        step();
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b want=0", s_valid); end
        checks++; if (s_ready !== '0) begin errors++; $display("FAIL reset_ready got=%b want=0", s_ready); end
        checks++; if (s_out !== '0 || s_cnt !== '0 || s_err !== 1'b0)
            begin errors++; $display("FAIL reset_outputs out=%h cnt=%0d err=%0b want all 0", s_out, s_cnt, s_err); end
        enq(3, SOM_EOM, 16'h00A5);
        step();
        checks++; if (s_ready !== 8'b0000_1000) begin errors++; $display("FAIL single_ready got=%b want=00001000", s_ready); end
        step();
        checks++; if (s_valid !== 1'b1 || s_out.data !== 16'h00A5 || s_out.pe !== 3'd3)
            begin errors++; $display("FAIL single_out valid=%0b data=%h pe=%0d want 1/00a5/3", s_valid, s_out.data, s_out.pe); end
        step();
        checks++; if (s_cnt !== 8'd1) begin errors++; $display("FAIL single_count got=%0d want=1", s_cnt); end
    endtask

    task automatic test_round_robin();
        bit ok;
        int exp_pe[6] = '{0, 1, 2, 0, 1, 2};
        do_reset();
        for (int r = 0; r < 2; r++) for (int p = 0; p < 3; p++) enq(p, SOM_EOM, DW'($urandom));
        run_until(6, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rr_timeout got=%0d beats want=6", obs_log.size()); end
        if (ok) for (int k = 0; k < 6; k++) begin
            checks++; if (obs_log[k].pe !== PIDW'(exp_pe[k]) || obs_cyc[k] !== obs_cyc[0] + k) begin
                errors++; $display("FAIL rr_seq[%0d] pe=%0d cyc=%0d want pe=%0d cyc=%0d", k, obs_log[k].pe, obs_cyc[k], exp_pe[k], obs_cyc[0] + k);
            end
        end
    endtask

    task automatic test_lock();
        bit ok;
        int exp_pe[8] = '{2, 5, 5, 5, 5, 2, 4, 1};
        logic [1:0] exp_c[8] = '{SOM_EOM, SOM, MOM, MOM, EOM, SOM_EOM, SOM_EOM, SOM_EOM};
        do_reset();
        enq(5, SOM, 16'h5000); enq(5, MOM, 16'h5001); enq(5, MOM, 16'h5002); enq(5, EOM, 16'h5003);
        enq(2, SOM_EOM, 16'h2000); enq(2, SOM_EOM, 16'h2001);
        run_until(6, 40, ok);
        enq(1, SOM_EOM, 16'h1000); enq(4, SOM_EOM, 16'h4000);
        if (ok) run_until(8, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL lock_timeout got=%0d beats want=8", obs_log.size()); end
        if (ok) for (int k = 0; k < 8; k++) begin
            checks++; if (obs_log[k].pe !== PIDW'(exp_pe[k]) || obs_log[k].cntl !== exp_c[k]) begin
                errors++; $display("FAIL lock_seq[%0d] pe=%0d cntl=%0d want pe=%0d cntl=%0d", k, obs_log[k].pe, obs_log[k].cntl, exp_pe[k], exp_c[k]);
            end
        end
        checks++; if (ok && obs_cyc[4] !== obs_cyc[1] + 3) begin errors++; $display("FAIL lock_contig cyc=%0d want=%0d", obs_cyc[4], obs_cyc[1] + 3); end
    endtask

    task automatic test_backpressure();
        bit ok;
        int per_pe[NP];
        do_reset();
        rdy_mode = 0;
        for (int r = 0; r < 2; r++) for (int p = 0; p < NP; p += 2) enq(p, SOM_EOM, DW'(p * 16 + r));
        repeat (5) step();
        checks++; if (dut_acc !== 2) begin errors++; $display("FAIL bp_accepts got=%0d want=2", dut_acc); end
        checks++; if (s_ready !== '0 || s_valid !== 1'b1) begin errors++; $display("FAIL bp_full ready=%b valid=%0b want 0/1", s_ready, s_valid); end
        checks++; if (stall_mm !== 0) begin errors++; $display("FAIL bp_stable changes=%0d want=0", stall_mm); end
        rdy_mode = 1;
        run_until(8, 40, ok);
        repeat (3) step();
        checks++; if (!ok || obs_log.size() !== 8) begin errors++; $display("FAIL bp_count got=%0d want=8", obs_log.size()); end
        foreach (per_pe[p]) per_pe[p] = 0;
        foreach (obs_log[k]) per_pe[obs_log[k].pe]++;
        for (int p = 0; p < NP; p++) begin
            checks++; if (per_pe[p] !== ((p % 2 == 0) ? 2 : 0)) begin
                errors++; $display("FAIL bp_pe%0d beats=%0d want=%0d", p, per_pe[p], (p % 2 == 0) ? 2 : 0);
            end
        end
        checks++; if (ready_mm !== 0 || valid_mm !== 0) begin errors++; $display("FAIL bp_model ready_mm=%0d valid_mm=%0d want 0", ready_mm, valid_mm); end
    endtask

    task automatic test_proto_err();
        bit ok;
        int exp_pe[4] = '{7, 7, 7, 1};
        do_reset();
        enq(7, SOM, 16'h7000);
        step();
        enq(7, SOM, 16'h7001); enq(7, EOM, 16'h7002); enq(1, SOM_EOM, 16'h1000);
        run_until(4, 30, ok);
        checks++; if (!ok) begin errors++; $display("FAIL perr_timeout got=%0d beats want=4", obs_log.size()); end
        if (ok) for (int k = 0; k < 4; k++) begin
            checks++; if (obs_log[k].pe !== PIDW'(exp_pe[k])) begin
                errors++; $display("FAIL perr_seq[%0d] pe=%0d want=%0d", k, obs_log[k].pe, exp_pe[k]);
            end
        end
        checks++; if (s_err !== 1'b1) begin errors++; $display("FAIL perr_set got=%0b want=1", s_err); end
        repeat (3) step();
        checks++; if (s_err !== 1'b1) begin errors++; $display("FAIL perr_sticky got=%0b want=1", s_err); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        rdy_mode = 0;
        enq(3, SOM, 16'h3000);
        for (int k = 1; k < 4; k++) enq(3, MOM, DW'(16'h3000 + k));
        enq(3, EOM, 16'h3004);
        repeat (4) step();
        rst = 1'b1;
        step();
        checks++; if (s_ready !== '0) begin errors++; $display("FAIL rstmid_ready_in_reset got=%b want=0", s_ready); end
        for (int p = 0; p < NP; p++) src_q[p].delete();
        rst = 1'b0;
        step();
        checks++; if (s_valid !== 1'b0 || s_ready !== '0 || s_out !== '0)
            begin errors++; $display("FAIL rstmid_after valid=%0b ready=%b out=%h want 0", s_valid, s_ready, s_out); end
        enq(5, SOM_EOM, 16'h5555); enq(2, SOM_EOM, 16'h2222);
        rdy_mode = 1;
        step();
        checks++; if (s_ready !== 8'b0000_0100) begin errors++; $display("FAIL rstmid_grant got=%b want=00000100", s_ready); end
        run_until(2, 20, ok);
        checks++; if (!ok || obs_log[0].data !== 16'h2222 || obs_log[1].data !== 16'h5555)
            begin errors++; $display("FAIL rstmid_replay beats=%0d want 2 beats 2222,5555 only", obs_log.size()); end
    endtask

    task automatic test_wrap();
        bit ok;
        do_reset();
        for (int m = 0; m < 255; m++) enq(m % NP, SOM_EOM, DW'(m));
        run_until(255, 700, ok);
        step();
        checks++; if (!ok || s_cnt !== 8'd255) begin errors++; $display("FAIL wrap_pre got=%0d want=255", s_cnt); end
        enq(0, SOM_EOM, 16'hF000);
        run_until(256, 20, ok);
        step();
        checks++; if (!ok || s_cnt !== 8'd0) begin errors++; $display("FAIL wrap_zero got=%0d want=0", s_cnt); end
        enq(1, SOM, 16'hF001); enq(1, EOM, 16'hF002);
        run_until(258, 20, ok);
        step();
        checks++; if (!ok || s_cnt !== 8'd1) begin errors++; $display("FAIL wrap_one got=%0d want=1", s_cnt); end
    endtask

    task automatic test_random();
        bit ok;
        int n_beats = 0, n_msgs = 60, len, p;
        logic exp_err = 1'b0;
        logic [1:0] c;
        logic [DW-1:0] gen_data[NP][$];
        int idx[NP];
        do_reset();
        bubble_pct = 30;
        rdy_mode = 2;
        for (int m = 0; m < n_msgs; m++) begin
            p = $urandom_range(NP - 1);
            len = $urandom_range(1, 4);
            for (int k = 0; k < len; k++) begin
                if (len == 1) c = SOM_EOM;
                else if (k == 0) c = SOM;
                else if (k == len - 1) c = EOM;
                else if ($urandom_range(9) == 0) begin c = SOM; exp_err = 1'b1; end
                else c = MOM;
                enq(p, c, DW'(p * 4096 + n_beats));
                gen_data[p].push_back(DW'(p * 4096 + n_beats));
                n_beats++;
            end
        end
        run_until(n_beats, 4000, ok);
        repeat (2) step();
        checks++; if (!ok || obs_log.size() !== n_beats || exp_log.size() !== n_beats)
            begin errors++; $display("FAIL rand_count got=%0d model=%0d want=%0d", obs_log.size(), exp_log.size(), n_beats); end
        if (ok) for (int k = 0; k < n_beats; k++) begin
            checks++; if (obs_log[k] !== exp_log[k]) begin
                errors++; $display("FAIL rand_beat[%0d] got=%h want=%h", k, obs_log[k], exp_log[k]);
            end
        end
        foreach (idx[q]) idx[q] = 0;
        ok = 1'b1;
        foreach (obs_log[k]) begin
            if (idx[obs_log[k].pe] >= gen_data[obs_log[k].pe].size() ||
                obs_log[k].data !== gen_data[obs_log[k].pe][idx[obs_log[k].pe]]) ok = 1'b0;
            idx[obs_log[k].pe]++;
        end
        checks++; if (!ok) begin errors++; $display("FAIL rand_pe_order got=out-of-order want=per-PE generation order"); end
        checks++; if (ready_mm !== 0 || valid_mm !== 0 || stall_mm !== 0)
            begin errors++; $display("FAIL rand_handshake ready_mm=%0d valid_mm=%0d stall_mm=%0d want 0", ready_mm, valid_mm, stall_mm); end
        checks++; if (s_cnt !== CNTW'(n_msgs)) begin errors++; $display("FAIL rand_msg_count got=%0d want=%0d", s_cnt, n_msgs); end
        checks++; if (s_err !== exp_err) begin errors++; $display("FAIL rand_proto_err got=%0b want=%0b", s_err, exp_err); end
        checks++; if (cnt_mm !== 0) begin errors++; $display("FAIL rand_counters cycles_off=%0d want=0", cnt_mm); end
    endtask

    initial begin
        pe_if.pe__stu__valid = '0;
        pe_if.pe__stu__cntl = '0;
        pe_if.pe__stu__type = '0;
        pe_if.pe__stu__data = '0;
        pe_if.pe__stu__oob_data = '0;
        sys_if.sys__stu__ready = 1'b0;
        test_reset();
        test_round_robin();
        test_lock();
        test_backpressure();
        test_proto_err();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
